// File: rtl/programcounter_stack_if.sv
// programcounter_stack_if: decoder-to-PC command bus and PC/stack status returned to the sequencer.
interface programcounter_stack_if #(parameter int N = 8);
  logic         en;
  logic [N-1:0] addr;
  logic         JP;
  logic         JF;
  logic         Flag;
  logic         CALL;
  logic         RET;
  logic [N-1:0] PC;
  logic         stack_empty;
  logic         stack_full;
  logic         overflow;
  logic         underflow;
  modport master (output en, addr, JP, JF, Flag, CALL, RET,
                  input PC, stack_empty, stack_full, overflow, underflow);
  modport slave  (input en, addr, JP, JF, Flag, CALL, RET,
                  output PC, stack_empty, stack_full, overflow, underflow);
endinterface

// File: rtl/programcounter_stack.sv
// programcounter_stack: PC with jump, conditional jump and call/return via a LIFO return stack.
// Define REL_JUMP_EN to make JP/JF targets PC-relative (addr as two's complement); CALL stays absolute.
module programcounter_stack #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  programcounter_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [N-1:0]  pc;
  logic [N-1:0]  stack [DEPTH];
  logic [CW-1:0] count;
  logic          ovf;
  logic          udf;
  logic [N-1:0]  inc;
  logic [N-1:0]  tgt;
  logic          empty;
  logic          full;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;
  logic          push;
  always_comb begin
    inc      = pc + 1'b1;
`ifdef REL_JUMP_EN
    tgt      = pc + bus.addr;
`else
    tgt      = bus.addr;
`endif
    empty    = count == '0;
    full     = count == CW'(DEPTH);
    push_idx = AW'(count);
    top_idx  = AW'(count - 1'b1);
    push     = bus.en && !bus.RET && bus.CALL && !full;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (bus.en) begin
      if (bus.RET) begin
        pc    <= empty ? inc : stack[top_idx];
        count <= empty ? count : count - 1'b1;
        udf   <= udf | empty;
      end else if (bus.CALL) begin
        pc    <= bus.addr;
        count <= full ? count : count + 1'b1;
        ovf   <= ovf | full;
      end else begin
        pc    <= (bus.JP || (bus.JF && bus.Flag)) ? tgt : inc;
      end
    end
  end
  // Return-address RAM carries no reset; entries above count are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && push) stack[push_idx] <= inc;
  end
  assign bus.PC          = pc;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.overflow    = ovf;
  assign bus.underflow   = udf;
endmodule
